// File: rtl/id_operand_stage.sv
// Decode-side operand stage: register file, operand forwarding, hazard detection
// and the valid/ready ID/EX pipeline register feeding EX.
module id_operand_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_REG = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CTRL_W  = 16,
    parameter bit          FWD_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [ADDR_W-1:0] id_rs1_add_i,
    input  logic [ADDR_W-1:0] id_rs2_add_i,
    input  logic              id_rs1_use_i,
    input  logic              id_rs2_use_i,
    input  logic [ADDR_W-1:0] id_rd_add_i,
    input  logic              id_regwrite_i,
    input  logic              id_mem_rd_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              ex_fwd_we_i,
    input  logic              ex_fwd_pend_i,
    input  logic [ADDR_W-1:0] ex_fwd_rd_i,
    input  logic [XLEN-1:0]   ex_fwd_data_i,
    input  logic              mem_fwd_we_i,
    input  logic              mem_fwd_pend_i,
    input  logic [ADDR_W-1:0] mem_fwd_rd_i,
    input  logic [XLEN-1:0]   mem_fwd_data_i,
    input  logic              wb_regwrite_i,
    input  logic [ADDR_W-1:0] wb_rd_add_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              ex_ready_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [ADDR_W-1:0] ex_rs1_add_o,
    output logic [ADDR_W-1:0] ex_rs2_add_o,
    output logic [ADDR_W-1:0] ex_rd_add_o,
    output logic              ex_regwrite_o,
    output logic              ex_mem_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              hazard_stall_o
);

    logic [XLEN-1:0]   rf [NUM_REG];
    logic [ADDR_W-1:0] src_add  [2];
    logic              src_use  [2];
    logic [XLEN-1:0]   src_data [2];
    logic              src_hz   [2];
    logic              hazard;
    logic              slot_free;
    logic              wb_wr;

    assign src_add[0] = id_rs1_add_i;
    assign src_add[1] = id_rs2_add_i;
    assign src_use[0] = id_rs1_use_i;
    assign src_use[1] = id_rs2_use_i;
    assign wb_wr      = wb_regwrite_i && (wb_rd_add_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REG; i++) rf[i] <= '0;
        end else if (wb_wr) begin
            rf[wb_rd_add_i] <= wb_data_i;
        end
    end

    // Youngest producer wins; without forwarding any in-flight EX/MEM match stalls until WB.
    always_comb begin
        logic ex_hit, mem_hit, wb_hit;
        for (int unsigned s = 0; s < 2; s++) begin
            ex_hit      = ex_fwd_we_i && (ex_fwd_rd_i == src_add[s]);
            mem_hit     = mem_fwd_we_i && (mem_fwd_rd_i == src_add[s]);
            wb_hit      = wb_regwrite_i && (wb_rd_add_i == src_add[s]);
            src_data[s] = '0;
            src_hz[s]   = 1'b0;
            if (src_add[s] != '0) begin
                if (ex_hit)       src_data[s] = ex_fwd_data_i;
                else if (mem_hit) src_data[s] = mem_fwd_data_i;
                else if (wb_hit)  src_data[s] = wb_data_i;
                else              src_data[s] = rf[src_add[s]];
                if (FWD_EN)
                    src_hz[s] = src_use[s] && (ex_hit ? ex_fwd_pend_i : (mem_hit && mem_fwd_pend_i));
                else
                    src_hz[s] = src_use[s] && (ex_hit || mem_hit);
            end
        end
    end

    assign hazard         = src_hz[0] || src_hz[1];
    assign slot_free      = !ex_valid_o || ex_ready_i;
    assign id_ready_o     = slot_free && !hazard;
    assign hazard_stall_o = id_valid_i && hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_imm_o      <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_rs1_add_o  <= '0;
            ex_rs2_add_o  <= '0;
            ex_rd_add_o   <= '0;
            ex_regwrite_o <= 1'b0;
            ex_mem_rd_o   <= 1'b0;
            ex_ctrl_o     <= '0;
        end else if (flush_i) begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_mem_rd_o   <= 1'b0;
        end else if (slot_free) begin
            if (id_valid_i && !hazard) begin
                ex_valid_o    <= 1'b1;
                ex_pc_o       <= id_pc_i;
                ex_imm_o      <= id_imm_i;
                ex_rs1_data_o <= src_data[0];
                ex_rs2_data_o <= src_data[1];
                ex_rs1_add_o  <= id_rs1_add_i;
                ex_rs2_add_o  <= id_rs2_add_i;
                ex_rd_add_o   <= id_rd_add_i;
                ex_regwrite_o <= id_regwrite_i;
                ex_mem_rd_o   <= id_mem_rd_i;
                ex_ctrl_o     <= id_ctrl_i;
            end else begin
                ex_valid_o    <= 1'b0;
                ex_regwrite_o <= 1'b0;
                ex_mem_rd_o   <= 1'b0;
            end
        end else begin
            // Held operands keep tracking WB so they are not stale when EX finally accepts.
            if (wb_wr && (wb_rd_add_i == ex_rs1_add_o)) ex_rs1_data_o <= wb_data_i;
            if (wb_wr && (wb_rd_add_i == ex_rs2_add_o)) ex_rs2_data_o <= wb_data_i;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: one forwarding and one non-forwarding
// instance, each checked every cycle against a rule-level model plus literal checks.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        id_valid_i = 1'b0;
    logic [31:0] id_pc_i = '0;
    logic [4:0]  id_rs1_add_i = '0;
    logic [4:0]  id_rs2_add_i = '0;
    logic        id_rs1_use_i = 1'b0;
    logic        id_rs2_use_i = 1'b0;
    logic [4:0]  id_rd_add_i = '0;
    logic        id_regwrite_i = 1'b0;
    logic        id_mem_rd_i = 1'b0;
    logic [31:0] id_imm_i = '0;
    logic [15:0] id_ctrl_i = '0;
    logic        ex_fwd_we_i = 1'b0;
    logic        ex_fwd_pend_i = 1'b0;
    logic [4:0]  ex_fwd_rd_i = '0;
    logic [31:0] ex_fwd_data_i = '0;
    logic        mem_fwd_we_i = 1'b0;
    logic        mem_fwd_pend_i = 1'b0;
    logic [4:0]  mem_fwd_rd_i = '0;
    logic [31:0] mem_fwd_data_i = '0;
    logic        wb_regwrite_i = 1'b0;
    logic [4:0]  wb_rd_add_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        ex_ready_i = 1'b1;

    // index 0: FWD_EN=1 instance, index 1: FWD_EN=0 instance
    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_imm   [2];
    logic [31:0] o_d1    [2];
    logic [31:0] o_d2    [2];
    logic [4:0]  o_a1    [2];
    logic [4:0]  o_a2    [2];
    logic [4:0]  o_rd    [2];
    logic        o_rw    [2];
    logic        o_mr    [2];
    logic [15:0] o_ctrl  [2];
    logic        o_stall [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_operand_stage #(.XLEN(32), .NUM_REG(32), .ADDR_W(5), .CTRL_W(16), .FWD_EN(1'b1)) u_dut_fwd (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .id_valid_i(id_valid_i), .id_ready_o(o_ready[0]),
        .id_pc_i(id_pc_i), .id_rs1_add_i(id_rs1_add_i), .id_rs2_add_i(id_rs2_add_i),
        .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i), .id_rd_add_i(id_rd_add_i),
        .id_regwrite_i(id_regwrite_i), .id_mem_rd_i(id_mem_rd_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
        .ex_fwd_we_i(ex_fwd_we_i), .ex_fwd_pend_i(ex_fwd_pend_i), .ex_fwd_rd_i(ex_fwd_rd_i), .ex_fwd_data_i(ex_fwd_data_i),
        .mem_fwd_we_i(mem_fwd_we_i), .mem_fwd_pend_i(mem_fwd_pend_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_rd_add_i(wb_rd_add_i), .wb_data_i(wb_data_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(o_valid[0]), .ex_pc_o(o_pc[0]), .ex_imm_o(o_imm[0]), .ex_rs1_data_o(o_d1[0]), .ex_rs2_data_o(o_d2[0]),
        .ex_rs1_add_o(o_a1[0]), .ex_rs2_add_o(o_a2[0]), .ex_rd_add_o(o_rd[0]), .ex_regwrite_o(o_rw[0]),
        .ex_mem_rd_o(o_mr[0]), .ex_ctrl_o(o_ctrl[0]), .hazard_stall_o(o_stall[0])
    );

    id_operand_stage #(.XLEN(32), .NUM_REG(32), .ADDR_W(5), .CTRL_W(16), .FWD_EN(1'b0)) u_dut_nofwd (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .id_valid_i(id_valid_i), .id_ready_o(o_ready[1]),
        .id_pc_i(id_pc_i), .id_rs1_add_i(id_rs1_add_i), .id_rs2_add_i(id_rs2_add_i),
        .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i), .id_rd_add_i(id_rd_add_i),
        .id_regwrite_i(id_regwrite_i), .id_mem_rd_i(id_mem_rd_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
        .ex_fwd_we_i(ex_fwd_we_i), .ex_fwd_pend_i(ex_fwd_pend_i), .ex_fwd_rd_i(ex_fwd_rd_i), .ex_fwd_data_i(ex_fwd_data_i),
        .mem_fwd_we_i(mem_fwd_we_i), .mem_fwd_pend_i(mem_fwd_pend_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_rd_add_i(wb_rd_add_i), .wb_data_i(wb_data_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(o_valid[1]), .ex_pc_o(o_pc[1]), .ex_imm_o(o_imm[1]), .ex_rs1_data_o(o_d1[1]), .ex_rs2_data_o(o_d2[1]),
        .ex_rs1_add_o(o_a1[1]), .ex_rs2_add_o(o_a2[1]), .ex_rd_add_o(o_rd[1]), .ex_regwrite_o(o_rw[1]),
        .ex_mem_rd_o(o_mr[1]), .ex_ctrl_o(o_ctrl[1]), .hazard_stall_o(o_stall[1])
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  a1, a2, rd;
        logic        rw, mr, u1, u2;
        logic [15:0] ctrl;
    } ex_t;

    ex_t         m   [2];
    logic [31:0] mrf [2][32];

    function automatic logic [31:0] operand(int k, logic [4:0] a);
        logic        we  [3];
        logic [4:0]  rds [3];
        logic [31:0] dat [3];
        if (a == 5'd0) return 32'd0;
        we[0] = ex_fwd_we_i;   rds[0] = ex_fwd_rd_i;  dat[0] = ex_fwd_data_i;
        we[1] = mem_fwd_we_i;  rds[1] = mem_fwd_rd_i; dat[1] = mem_fwd_data_i;
        we[2] = wb_regwrite_i; rds[2] = wb_rd_add_i;  dat[2] = wb_data_i;
        for (int i = 0; i < 3; i++)
            if (we[i] && rds[i] == a) return dat[i];
        return mrf[k][a];
    endfunction

    function automatic logic blocked(int k, logic [4:0] a, logic used);
        logic ex_m, mem_m;
        if (!used || a == 5'd0) return 1'b0;
        ex_m  = ex_fwd_we_i && ex_fwd_rd_i == a;
        mem_m = mem_fwd_we_i && mem_fwd_rd_i == a;
        if (k == 1) return ex_m || mem_m;
        if (ex_m) return ex_fwd_pend_i;
        if (mem_m) return mem_fwd_pend_i;
        return 1'b0;
    endfunction

    function automatic logic hz(int k);
        return blocked(k, id_rs1_add_i, id_rs1_use_i) || blocked(k, id_rs2_add_i, id_rs2_use_i);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m[k] = '{valid: 1'b0, pc: '0, imm: '0, d1: '0, d2: '0, a1: '0, a2: '0, rd: '0,
                         rw: 1'b0, mr: 1'b0, u1: 1'b0, u2: 1'b0, ctrl: '0};
                for (int r = 0; r < 32; r++) mrf[k][r] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                ex_t n;
                n = m[k];
                if (flush_i) begin
                    n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
                end else if (m[k].valid && !ex_ready_i) begin
                    if (wb_regwrite_i && wb_rd_add_i != 5'd0 && wb_rd_add_i == m[k].a1) n.d1 = wb_data_i;
                    if (wb_regwrite_i && wb_rd_add_i != 5'd0 && wb_rd_add_i == m[k].a2) n.d2 = wb_data_i;
                end else if (id_valid_i && !hz(k)) begin
                    n.valid = 1'b1;           n.pc = id_pc_i;          n.imm = id_imm_i;
                    n.d1 = operand(k, id_rs1_add_i);
                    n.d2 = operand(k, id_rs2_add_i);
                    n.a1 = id_rs1_add_i;      n.a2 = id_rs2_add_i;     n.rd = id_rd_add_i;
                    n.rw = id_regwrite_i;     n.mr = id_mem_rd_i;      n.ctrl = id_ctrl_i;
                    n.u1 = id_rs1_use_i;      n.u2 = id_rs2_use_i;
                end else begin
                    n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
                end
                if (wb_regwrite_i && wb_rd_add_i != 5'd0) mrf[k][wb_rd_add_i] = wb_data_i;
                m[k] = n;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valid[%0d]", k), 32'(o_valid[k]), 32'(m[k].valid));
            chk($sformatf("regwrite[%0d]", k), 32'(o_rw[k]), 32'(m[k].rw));
            chk($sformatf("mem_rd[%0d]", k), 32'(o_mr[k]), 32'(m[k].mr));
            chk($sformatf("id_ready[%0d]", k), 32'(o_ready[k]), 32'((!m[k].valid || ex_ready_i) && !hz(k)));
            chk($sformatf("stall[%0d]", k), 32'(o_stall[k]), 32'(id_valid_i && hz(k)));
            if (m[k].valid) begin
                chk($sformatf("pc[%0d]", k), o_pc[k], m[k].pc);
                chk($sformatf("imm[%0d]", k), o_imm[k], m[k].imm);
                chk($sformatf("rs1_add[%0d]", k), 32'(o_a1[k]), 32'(m[k].a1));
                chk($sformatf("rs2_add[%0d]", k), 32'(o_a2[k]), 32'(m[k].a2));
                chk($sformatf("rd_add[%0d]", k), 32'(o_rd[k]), 32'(m[k].rd));
                chk($sformatf("ctrl[%0d]", k), 32'(o_ctrl[k]), 32'(m[k].ctrl));
                if (m[k].u1) chk($sformatf("rs1_data[%0d]", k), o_d1[k], m[k].d1);
                if (m[k].u2) chk($sformatf("rs2_data[%0d]", k), o_d2[k], m[k].d2);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fwd_clear();
        ex_fwd_we_i = 1'b0;  ex_fwd_pend_i = 1'b0;  ex_fwd_rd_i = '0;  ex_fwd_data_i = '0;
        mem_fwd_we_i = 1'b0; mem_fwd_pend_i = 1'b0; mem_fwd_rd_i = '0; mem_fwd_data_i = '0;
        wb_regwrite_i = 1'b0; wb_rd_add_i = '0; wb_data_i = '0;
    endtask

    task automatic id_set(input logic v, input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                          input logic u2, input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [31:0] pc);
        id_valid_i = v; id_rs1_add_i = a1; id_rs1_use_i = u1; id_rs2_add_i = a2; id_rs2_use_i = u2;
        id_rd_add_i = rd; id_regwrite_i = rw; id_mem_rd_i = mr; id_pc_i = pc;
        id_imm_i = pc ^ 32'h5A5A_0000; id_ctrl_i = pc[17:2];
    endtask

    initial begin
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset valid[%0d]", k), 32'(o_valid[k]), 32'd0);
            chk($sformatf("reset ready[%0d]", k), 32'(o_ready[k]), 32'd1);
        end

        // WB write-through into a same-cycle read, then read back from the file
        fwd_clear();
        wb_regwrite_i = 1'b1; wb_rd_add_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
        id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 32'h100);
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("wthru rs1[%0d]", k), o_d1[k], 32'hDEAD_BEEF);
        fwd_clear();
        id_set(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 32'h104);
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("rf x5[%0d]", k), o_d2[k], 32'hDEAD_BEEF);

        // forwarding priority EX > MEM > WB, and x0
        ex_fwd_we_i = 1'b1;  ex_fwd_rd_i = 5'd3;  ex_fwd_data_i = 32'h11;
        mem_fwd_we_i = 1'b1; mem_fwd_rd_i = 5'd3; mem_fwd_data_i = 32'h22;
        wb_regwrite_i = 1'b1; wb_rd_add_i = 5'd3; wb_data_i = 32'h33;
        id_set(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h108);
        step();
        chk("prio ex", o_d1[0], 32'h11);
        chk("nofwd ex bubble", 32'(o_valid[1]), 32'd0);
        ex_fwd_we_i = 1'b0;
        step();
        chk("prio mem", o_d1[0], 32'h22);
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h10C);
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("x0 rs1[%0d]", k), o_d1[k], 32'd0);

        // load-use on rs2
        fwd_clear();
        ex_fwd_we_i = 1'b1; ex_fwd_pend_i = 1'b1; ex_fwd_rd_i = 5'd7; ex_fwd_data_i = 32'hEE;
        id_set(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 32'h110);
        #1;
        chk("lu stall", 32'(o_stall[0]), 32'd1);
        chk("lu ready", 32'(o_ready[0]), 32'd0);
        step();
        chk("lu bubble", 32'(o_valid[0]), 32'd0);
        fwd_clear();
        mem_fwd_we_i = 1'b1; mem_fwd_rd_i = 5'd7; mem_fwd_data_i = 32'h55;
        step();
        chk("lu valid", 32'(o_valid[0]), 32'd1);
        chk("lu rs2", o_d2[0], 32'h55);

        // no-forward instance waits for WB
        fwd_clear();
        ex_fwd_we_i = 1'b1; ex_fwd_rd_i = 5'd9; ex_fwd_data_i = 32'h99;
        id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h114);
        #1;
        chk("nofwd stall ex", 32'(o_stall[1]), 32'd1);
        step();
        chk("nofwd bubble 1", 32'(o_valid[1]), 32'd0);
        fwd_clear();
        mem_fwd_we_i = 1'b1; mem_fwd_rd_i = 5'd9; mem_fwd_data_i = 32'h99;
        #1;
        chk("nofwd stall mem", 32'(o_stall[1]), 32'd1);
        step();
        chk("nofwd bubble 2", 32'(o_valid[1]), 32'd0);
        fwd_clear();
        wb_regwrite_i = 1'b1; wb_rd_add_i = 5'd9; wb_data_i = 32'h99;
        #1;
        chk("nofwd ready wb", 32'(o_ready[1]), 32'd1);
        step();
        chk("nofwd valid", 32'(o_valid[1]), 32'd1);
        chk("nofwd rs1", o_d1[1], 32'h99);

        // backpressure with WB snoop, then flush during the hold
        fwd_clear();
        id_set(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b1, 32'h200);
        step();
        ex_ready_i = 1'b0;
        id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 32'h204);
        wb_regwrite_i = 1'b1; wb_rd_add_i = 5'd10; wb_data_i = 32'hAAAA;
        step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("hold pc[%0d]", k), o_pc[k], 32'h200);
            chk($sformatf("snoop rs1[%0d]", k), o_d1[k], 32'hAAAA);
            chk($sformatf("hold ready[%0d]", k), 32'(o_ready[k]), 32'd0);
        end
        fwd_clear();
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("hold3 pc[%0d]", k), o_pc[k], 32'h200);
            chk($sformatf("hold3 mem_rd[%0d]", k), 32'(o_mr[k]), 32'd1);
        end
        flush_i = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("flush valid[%0d]", k), 32'(o_valid[k]), 32'd0);
            chk($sformatf("flush regwrite[%0d]", k), 32'(o_rw[k]), 32'd0);
        end
        flush_i = 1'b0;
        ex_ready_i = 1'b1;
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("after flush pc[%0d]", k), o_pc[k], 32'h204);

        // async reset in the middle of a stall with EX held
        id_set(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd14, 1'b1, 1'b0, 32'h300);
        step();
        ex_ready_i = 1'b0;
        ex_fwd_we_i = 1'b1; ex_fwd_pend_i = 1'b1; ex_fwd_rd_i = 5'd3;
        id_set(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 32'h304);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("areset valid[%0d]", k), 32'(o_valid[k]), 32'd0);
            chk($sformatf("areset pc[%0d]", k), o_pc[k], 32'd0);
            chk($sformatf("areset regwrite[%0d]", k), 32'(o_rw[k]), 32'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        fwd_clear();
        ex_ready_i = 1'b1;
        for (int i = 1; i < 32; i++) begin
            id_set(1'b1, 5'(i), 1'b1, 5'(i), 1'b1, 5'd0, 1'b0, 1'b0, 32'h400 + 32'(4 * i));
            step();
            chk($sformatf("cleared x%0d", i), o_d1[0] | o_d1[1] | o_d2[0] | o_d2[1], 32'd0);
        end
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("idle bubble[%0d]", k), 32'(o_valid[k]), 32'd0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
